// File: rtl/inst_issue_ctrl.sv
// In-order instruction issue queue with per-register busy scoreboarding.
// Instructions are queued FIFO and the head issues once its registers are clear.
module inst_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int LAT   = 3,
  parameter int NREGS = 16,
  localparam int OPW  = 8,
  localparam int DW   = 16,
  localparam int RW   = $clog2(NREGS),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_opcode,
  input  logic [DW-1:0]  in_imm,
  input  logic [RW-1:0]  in_src1,
  input  logic [RW-1:0]  in_src2,
  input  logic [RW-1:0]  in_dst,
  output logic           instv,
  output logic [OPW-1:0] opcode,
  output logic [DW-1:0]  imm,
  output logic [RW-1:0]  src1,
  output logic [RW-1:0]  src2,
  output logic [RW-1:0]  dst,
  output logic           stall,
  output logic [CW-1:0]  count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  imm;
    logic [RW-1:0]  src1;
    logic [RW-1:0]  src2;
    logic [RW-1:0]  dst;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  entry_t        in_entry;
  entry_t        out_q, out_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    busy_q [NREGS];
  logic [2:0]    busy_d [NREGS];
  logic          instv_q, instv_d;
  logic          push, pop, issuable;

  // A counter of 1 expires at this edge, so a dependent instruction may issue
  // on it; this yields exactly LAT-1 bubbles behind a producer.
  function automatic logic reg_blocked(input logic [2:0] b);
    return b > 3'd1;
  endfunction

  always_comb begin
    in_entry = '{op: in_opcode, imm: in_imm, src1: in_src1, src2: in_src2, dst: in_dst};
    head     = mem_q[rd_ptr_q];
    in_ready = !reset && (count_q != CW'(DEPTH));
    push     = in_valid && in_ready;
    issuable = (count_q != '0)
               && !reg_blocked(busy_q[head.src1])
               && !reg_blocked(busy_q[head.src2])
               && !reg_blocked(busy_q[head.dst]);
    pop      = issuable;
    stall    = (count_q != '0) && !issuable;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    instv_d  = pop;
    out_d    = pop ? head : out_q;
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      busy_d[i] = busy_q[i];
      if (pop && (head.dst == RW'(i))) begin
        busy_d[i] = 3'(LAT);
      end else if (busy_q[i] != 3'd0) begin
        busy_d[i] = busy_q[i] - 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      instv_q  <= 1'b0;
      out_q    <= '0;
      for (int i = 0; i < NREGS; i++) begin
        busy_q[i] <= 3'd0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      instv_q  <= instv_d;
      out_q    <= out_d;
      for (int i = 0; i < NREGS; i++) begin
        busy_q[i] <= busy_d[i];
      end
    end
  end

  // Queue storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  assign instv  = instv_q;
  assign opcode = out_q.op;
  assign imm    = out_q.imm;
  assign src1   = out_q.src1;
  assign src2   = out_q.src2;
  assign dst    = out_q.dst;
  assign count  = count_q;

endmodule

// File: tb/tb_inst_issue_ctrl.sv
// Directed bench for inst_issue_ctrl: hazard timing, queue fill and reset flush.
module tb_inst_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_opcode = '0;
  logic [15:0] in_imm = '0;
  logic [3:0]  in_src1 = '0, in_src2 = '0, in_dst = '0;
  logic        instv;
  logic [7:0]  opcode;
  logic [15:0] imm;
  logic [3:0]  src1, src2, dst;
  logic        stall;
  logic [2:0]  count;

  int vecs = 0;
  int errs = 0;

  inst_issue_ctrl #(.DEPTH(4), .LAT(3), .NREGS(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_imm(in_imm), .in_src1(in_src1), .in_src2(in_src2),
    .in_dst(in_dst), .instv(instv), .opcode(opcode), .imm(imm), .src1(src1),
    .src2(src2), .dst(dst), .stall(stall), .count(count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [7:0] op, input logic [15:0] im,
                        input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d);
    in_valid = v; in_opcode = op; in_imm = im; in_src1 = s1; in_src2 = s2; in_dst = d;
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 8'h0, 16'h0, 4'd0, 4'd0, 4'd0);
    repeat (n) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_ready_low got %b exp 0", in_ready); end
    reset = 1'b0;
    step();
    vecs++; if (instv !== 1'b0) begin errs++; $display("FAIL rst_instv got %b exp 0", instv); end
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL rst_stall got %b exp 0", stall); end
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL rst_count got %0d exp 0", count); end
    vecs++; if ({opcode, imm, src1, src2, dst} !== 36'd0) begin errs++; $display("FAIL rst_fields got %h exp 0", {opcode, imm, src1, src2, dst}); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_ready_high got %b exp 1", in_ready); end
  endtask

  task automatic test_independent();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 8'h10 + 8'(i), 16'hA000 + 16'(i), 4'd8, 4'd9, 4'(i + 1));
      step();
      vecs++; if (instv !== (i != 0)) begin errs++; $display("FAIL ind_instv_%0d got %b exp %b", i, instv, (i != 0)); end
      vecs++; if (count !== 3'd1) begin errs++; $display("FAIL ind_count_%0d got %0d exp 1", i, count); end
      if (i != 0) begin
        vecs++; if (dst !== 4'(i)) begin errs++; $display("FAIL ind_dst_%0d got %0d exp %0d", i, dst, i); end
        vecs++; if (imm !== 16'hA000 + 16'(i - 1)) begin errs++; $display("FAIL ind_imm_%0d got %h exp %h", i, imm, 16'hA000 + 16'(i - 1)); end
      end
    end
    set_in(1'b0, 8'h0, 16'h0, 4'd0, 4'd0, 4'd0);
    step();
    vecs++; if (instv !== 1'b1 || dst !== 4'd4 || opcode !== 8'h13) begin errs++; $display("FAIL ind_last got v=%b d=%0d op=%h exp v=1 d=4 op=13", instv, dst, opcode); end
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL ind_drain_count got %0d exp 0", count); end
    step();
    vecs++; if (instv !== 1'b0 || dst !== 4'd4) begin errs++; $display("FAIL ind_hold got v=%b d=%0d exp v=0 d=4", instv, dst); end
    idle(4);
  endtask

  task automatic test_raw();
    set_in(1'b1, 8'h21, 16'h0AAA, 4'd8, 4'd9, 4'd2);
    step();
    set_in(1'b1, 8'h22, 16'h0BBB, 4'd2, 4'd9, 4'd6);
    step();
    vecs++; if (instv !== 1'b1 || dst !== 4'd2) begin errs++; $display("FAIL raw_e1 got v=%b d=%0d exp v=1 d=2", instv, dst); end
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL raw_stall_e1 got %b exp 1", stall); end
    set_in(1'b0, 8'h0, 16'h0, 4'd0, 4'd0, 4'd0);
    step();
    vecs++; if (instv !== 1'b0 || stall !== 1'b1) begin errs++; $display("FAIL raw_e2 got v=%b s=%b exp v=0 s=1", instv, stall); end
    step();
    vecs++; if (instv !== 1'b0 || stall !== 1'b0) begin errs++; $display("FAIL raw_e3 got v=%b s=%b exp v=0 s=0", instv, stall); end
    step();
    vecs++; if (instv !== 1'b1 || dst !== 4'd6 || src1 !== 4'd2 || imm !== 16'h0BBB) begin errs++; $display("FAIL raw_e4 got v=%b d=%0d s1=%0d imm=%h exp v=1 d=6 s1=2 imm=0bbb", instv, dst, src1, imm); end
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL raw_count got %0d exp 0", count); end
    idle(4);
  endtask

  task automatic test_full();
    set_in(1'b1, 8'h30, 16'h0100, 4'd8, 4'd9, 4'd5);
    step();
    vecs++; if (count !== 3'd1) begin errs++; $display("FAIL full_p0_count got %0d exp 1", count); end
    set_in(1'b1, 8'h31, 16'h0101, 4'd8, 4'd9, 4'd5);
    step();
    vecs++; if (instv !== 1'b1 || imm !== 16'h0100 || count !== 3'd1) begin errs++; $display("FAIL full_p1 got v=%b imm=%h c=%0d exp v=1 imm=0100 c=1", instv, imm, count); end
    set_in(1'b1, 8'h32, 16'h0102, 4'd8, 4'd9, 4'd5);
    step();
    vecs++; if (count !== 3'd2 || stall !== 1'b1 || instv !== 1'b0) begin errs++; $display("FAIL full_p2 got c=%0d s=%b v=%b exp c=2 s=1 v=0", count, stall, instv); end
    set_in(1'b1, 8'h33, 16'h0103, 4'd8, 4'd9, 4'd5);
    step();
    vecs++; if (count !== 3'd3 || stall !== 1'b0) begin errs++; $display("FAIL full_p3 got c=%0d s=%b exp c=3 s=0", count, stall); end
    set_in(1'b1, 8'h34, 16'h0104, 4'd8, 4'd9, 4'd5);
    step();
    vecs++; if (instv !== 1'b1 || imm !== 16'h0101 || count !== 3'd3 || stall !== 1'b1) begin errs++; $display("FAIL full_p4 got v=%b imm=%h c=%0d s=%b exp v=1 imm=0101 c=3 s=1", instv, imm, count, stall); end
    set_in(1'b1, 8'h35, 16'h0105, 4'd8, 4'd9, 4'd5);
    step();
    vecs++; if (count !== 3'd4 || in_ready !== 1'b0 || stall !== 1'b1) begin errs++; $display("FAIL full_p5 got c=%0d r=%b s=%b exp c=4 r=0 s=1", count, in_ready, stall); end
    set_in(1'b1, 8'h36, 16'h0106, 4'd8, 4'd9, 4'd5);
    step();
    vecs++; if (count !== 3'd4 || in_ready !== 1'b0 || instv !== 1'b0 || stall !== 1'b0) begin errs++; $display("FAIL full_p6 got c=%0d r=%b v=%b s=%b exp c=4 r=0 v=0 s=0", count, in_ready, instv, stall); end
    step();
    vecs++; if (instv !== 1'b1 || imm !== 16'h0102 || count !== 3'd3 || in_ready !== 1'b1) begin errs++; $display("FAIL full_issue got v=%b imm=%h c=%0d r=%b exp v=1 imm=0102 c=3 r=1", instv, imm, count, in_ready); end
    step();
    vecs++; if (count !== 3'd4 || instv !== 1'b0) begin errs++; $display("FAIL full_repush got c=%0d v=%b exp c=4 v=0", count, instv); end
    set_in(1'b0, 8'h0, 16'h0, 4'd0, 4'd0, 4'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL full_flush got c=%0d exp 0", count); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, 8'h40, 16'h0200, 4'd8, 4'd9, 4'd5);
    step();
    set_in(1'b1, 8'h41, 16'h0201, 4'd5, 4'd9, 4'd2);
    step();
    set_in(1'b1, 8'h42, 16'h0202, 4'd2, 4'd8, 4'd9);
    step();
    set_in(1'b1, 8'h43, 16'h0203, 4'd8, 4'd8, 4'd10);
    step();
    vecs++; if (count !== 3'd3) begin errs++; $display("FAIL mid_p3_count got %0d exp 3", count); end
    set_in(1'b1, 8'h44, 16'h0204, 4'd8, 4'd8, 4'd11);
    step();
    vecs++; if (instv !== 1'b1 || dst !== 4'd2 || count !== 3'd3) begin errs++; $display("FAIL mid_p4 got v=%b d=%0d c=%0d exp v=1 d=2 c=3", instv, dst, count); end
    set_in(1'b0, 8'h0, 16'h0, 4'd0, 4'd0, 4'd0);
    step();
    vecs++; if (count !== 3'd3 || stall !== 1'b1 || instv !== 1'b0) begin errs++; $display("FAIL mid_p5 got c=%0d s=%b v=%b exp c=3 s=1 v=0", count, stall, instv); end
    reset = 1'b1;
    set_in(1'b1, 8'h66, 16'h0666, 4'd8, 4'd8, 4'd12);
    #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL mid_ready_in_reset got %b exp 0", in_ready); end
    step();
    vecs++; if (count !== 3'd0 || instv !== 1'b0 || stall !== 1'b0) begin errs++; $display("FAIL mid_after_reset got c=%0d v=%b s=%b exp c=0 v=0 s=0", count, instv, stall); end
    vecs++; if ({opcode, imm, src1, src2, dst} !== 36'd0) begin errs++; $display("FAIL mid_fields got %h exp 0", {opcode, imm, src1, src2, dst}); end
    reset = 1'b0;
    set_in(1'b1, 8'h55, 16'h0555, 4'd2, 4'd8, 4'd3);
    step();
    vecs++; if (instv !== 1'b0 || count !== 3'd1 || stall !== 1'b0) begin errs++; $display("FAIL mid_push got v=%b c=%0d s=%b exp v=0 c=1 s=0", instv, count, stall); end
    set_in(1'b0, 8'h0, 16'h0, 4'd0, 4'd0, 4'd0);
    step();
    vecs++; if (instv !== 1'b1 || opcode !== 8'h55 || src1 !== 4'd2 || dst !== 4'd3 || count !== 3'd0) begin errs++; $display("FAIL mid_fresh got v=%b op=%h s1=%0d d=%0d c=%0d exp v=1 op=55 s1=2 d=3 c=0", instv, opcode, src1, dst, count); end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw();
    test_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
